// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage with one outstanding imem request, skid buffer and IF/ID register
// Redirects squash IF/ID and the skid; an in-flight response after a redirect is drained.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        skid_full_q, skid_full_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;

  logic        req_hs;
  logic        deliver;
  logic        in_flight;

  assign imem_req_valid = !rst && (state_q == S_REQ) && !skid_full_q;
  assign imem_addr      = pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign deliver        = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
  // A DRAIN still waiting on its stale word counts as in flight too.
  assign in_flight      = req_hs
                       || ((state_q == S_WAIT)  && !imem_rsp_valid)
                       || ((state_q == S_DRAIN) && !imem_rsp_valid);

  assign if_id_valid = if_id_valid_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_pc_d = req_pc_q;
    case (state_q)
      S_REQ: begin
        if (req_hs) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) state_d = S_REQ;
      end
      S_DRAIN: begin
        if (imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      state_d = in_flight ? S_DRAIN : S_REQ;
    end
  end

  always_comb begin
    skid_full_d   = skid_full_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if (redirect_valid) begin
      if_id_valid_d = 1'b0;
      skid_full_d   = 1'b0;
    end else if (!stall) begin
      if (skid_full_q) begin
        if_id_valid_d = 1'b1;
        if_id_pc_d    = skid_pc_q;
        if_id_instr_d = skid_instr_q;
        // Skid stays older than the new word, so the new word backfills it.
        if (deliver) begin
          skid_pc_d    = req_pc_q;
          skid_instr_d = imem_rsp_data;
        end else begin
          skid_full_d  = 1'b0;
        end
      end else if (deliver) begin
        if_id_valid_d = 1'b1;
        if_id_pc_d    = req_pc_q;
        if_id_instr_d = imem_rsp_data;
      end else begin
        if_id_valid_d = 1'b0;
      end
    end else if (deliver) begin
      if (if_id_valid_q) begin
        skid_full_d  = 1'b1;
        skid_pc_d    = req_pc_q;
        skid_instr_d = imem_rsp_data;
      end else begin
        if_id_valid_d = 1'b1;
        if_id_pc_d    = req_pc_q;
        if_id_instr_d = imem_rsp_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_full_q   <= 1'b0;
      skid_pc_q     <= 32'h0;
      skid_instr_q  <= NOP;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= NOP;
    end else begin
      skid_full_q   <= skid_full_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed vector bench for instruction_fetch_unit
// A second instance with RESET_PC=FFFF_FFFC runs in lockstep to cover PC wrap.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;

  logic        req_valid_a, req_valid_b;
  logic [31:0] addr_a, addr_b;
  logic        ifv_a, ifv_b;
  logic [31:0] ifpc_a, ifpc_b;
  logic [31:0] instr_a, instr_b;

  int checks;
  int failures;
  bit auto_rsp;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid_a), .imem_req_ready(imem_req_ready), .imem_addr(addr_a),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .if_id_valid(ifv_a), .if_id_pc(ifpc_a), .if_id_instr(instr_a)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid_b), .imem_req_ready(imem_req_ready), .imem_addr(addr_b),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .if_id_valid(ifv_b), .if_id_pc(ifpc_b), .if_id_instr(instr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Sample handshake at negedge; responses are driven 1 after the next posedge.
  task automatic cyc();
    logic        hs;
    logic [31:0] ha;
    @(negedge clk);
    hs = req_valid_a && imem_req_ready;
    ha = addr_a;
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      imem_rsp_valid = hs;
      imem_rsp_data  = hs ? mem_word(ha) : 32'h0;
    end else begin
      imem_rsp_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, req_valid_a}, 32'd0);
    chk("rst_ifv", {31'b0, ifv_a}, 32'd0);
    chk("rst_ifpc", ifpc_a, 32'd0);
    chk("rst_instr", instr_a, 32'h0000_0013);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_ifpc;
  } vec_t;

  vec_t vecs[16];

  initial begin
    checks   = 0;
    failures = 0;
    auto_rsp = 1'b1;
    rst      = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;

    // stall, ready, req_valid, addr, if_id_valid, if_id_pc
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'd4,  1'b0, 32'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'd4,  1'b1, 32'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'd8,  1'b0, 32'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'd8,  1'b1, 32'd4};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'd12, 1'b0, 32'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd8};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'd16, 1'b1, 32'd8};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'd16, 1'b1, 32'd8};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'd16, 1'b1, 32'd8};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'd16, 1'b1, 32'd8};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'd16, 1'b1, 32'd8};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'd16, 1'b1, 32'd8};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 32'd16, 1'b1, 32'd12};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 32'd20, 1'b0, 32'd0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 32'd20, 1'b1, 32'd16};

    // Streaming, stall with skid fill, and wrap on the second instance
    do_reset();
    for (int i = 0; i < 16; i++) begin
      stall          = vecs[i].stall;
      imem_req_ready = vecs[i].ready;
      redirect_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_req_valid", i), {31'b0, req_valid_a}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i), addr_a, vecs[i].e_addr);
      chk($sformatf("v%0d_addr_wrap", i), addr_b, vecs[i].e_addr + 32'hFFFF_FFFC);
      chk($sformatf("v%0d_ifv", i), {31'b0, ifv_a}, {31'b0, vecs[i].e_ifv});
      if (vecs[i].e_ifv) begin
        chk($sformatf("v%0d_ifpc", i), ifpc_a, vecs[i].e_ifpc);
        chk($sformatf("v%0d_instr", i), instr_a, mem_word(vecs[i].e_ifpc));
        chk($sformatf("v%0d_ifpc_wrap", i), ifpc_b, vecs[i].e_ifpc + 32'hFFFF_FFFC);
      end
      cyc();
    end

    // Redirect while waiting with no response: drain the stale word
    auto_rsp = 1'b0;
    do_reset();
    imem_req_ready = 1'b1;
    #1;
    chk("rd_req0", {31'b0, req_valid_a}, 32'd1);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    chk("rd_wait_req", {31'b0, req_valid_a}, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    #1;
    chk("rd_drain_req", {31'b0, req_valid_a}, 32'd0);
    chk("rd_drain_addr", addr_a, 32'h0000_0100);
    cyc();
    imem_req_ready = 1'b0;
    #1;
    chk("rd_req_after", {31'b0, req_valid_a}, 32'd1);
    chk("rd_addr_after", addr_a, 32'h0000_0100);
    chk("rd_ifv_dropped", {31'b0, ifv_a}, 32'd0);
    cyc();
    imem_req_ready = 1'b1;
    #1;
    chk("rd_addr_hold", addr_a, 32'h0000_0100);
    chk("rd_req_hold", {31'b0, req_valid_a}, 32'd1);
    cyc();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;
    #1;
    chk("rd_wait2_req", {31'b0, req_valid_a}, 32'd0);
    cyc();
    #1;
    chk("rd_ifv", {31'b0, ifv_a}, 32'd1);
    chk("rd_ifpc", ifpc_a, 32'h0000_0100);
    chk("rd_instr", instr_a, 32'h0050_0093);

    // Redirect coincident with a response while stalled
    auto_rsp = 1'b1;
    do_reset();
    imem_req_ready = 1'b1;
    #1;
    cyc();
    #1;
    cyc();
    stall = 1'b1;
    #1;
    chk("rs_ifv_pre", {31'b0, ifv_a}, 32'd1);
    chk("rs_ifpc_pre", ifpc_a, 32'd0);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    chk("rs_rsp_present", {31'b0, imem_rsp_valid}, 32'd1);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("rs_ifv_squash", {31'b0, ifv_a}, 32'd0);
    chk("rs_req_skid_empty", {31'b0, req_valid_a}, 32'd1);
    chk("rs_addr_target", addr_a, 32'h0000_0200);
    cyc();
    #1;
    chk("rs_ifv_wait", {31'b0, ifv_a}, 32'd0);
    cyc();
    #1;
    chk("rs_ifv_new", {31'b0, ifv_a}, 32'd1);
    chk("rs_ifpc_new", ifpc_a, 32'h0000_0200);
    chk("rs_instr_new", instr_a, mem_word(32'h0000_0200));
    cyc();
    #1;
    chk("rs_ifpc_hold", ifpc_a, 32'h0000_0200);

    // Asynchronous reset mid-WAIT, then a stale response after release
    auto_rsp = 1'b0;
    do_reset();
    imem_req_ready = 1'b1;
    #1;
    cyc();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mem_word(32'd0);
    #1;
    cyc();
    stall = 1'b1;
    #1;
    cyc();
    #1;
    chk("ar_ifv_pre", {31'b0, ifv_a}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_req_valid", {31'b0, req_valid_a}, 32'd0);
    chk("ar_ifv", {31'b0, ifv_a}, 32'd0);
    chk("ar_ifpc", ifpc_a, 32'd0);
    chk("ar_instr", instr_a, 32'h0000_0013);
    chk("ar_addr", addr_a, 32'd0);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    stall          = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    #1;
    chk("ar_first_req", {31'b0, req_valid_a}, 32'd1);
    chk("ar_first_addr", addr_a, 32'd0);
    chk("ar_first_addr_wrap", addr_b, 32'hFFFF_FFFC);
    cyc();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mem_word(32'd0);
    #1;
    chk("ar_stale_ignored", {31'b0, ifv_a}, 32'd0);
    cyc();
    #1;
    chk("ar_ifv_new", {31'b0, ifv_a}, 32'd1);
    chk("ar_ifpc_new", ifpc_a, 32'd0);
    chk("ar_instr_new", instr_a, mem_word(32'd0));
    chk("ar_next_addr", addr_a, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
